// File: rtl/mcu_spi.sv
// MCU-facing SPI mode-0 target: oversamples the MCU pins, assembles MSB-first bytes and
// routes each frame to sysctrl, hid or sdc by its leading target byte, shifting replies back on MISO.
module mcu_spi #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  TARGET_SYS  = 8'd0,
  parameter logic [7:0]  TARGET_HID  = 8'd1,
  parameter logic [7:0]  TARGET_SDC  = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_start,
  output logic [7:0] mcu_dout,
  output logic       mcu_sys_strb,
  output logic       mcu_hid_strb,
  output logic       mcu_sdc_strb,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_sdc_din
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TGT  = 2'd1,
    ST_CMD  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_SYS  = 2'd1;
  localparam logic [1:0] KIND_HID  = 2'd2;
  localparam logic [1:0] KIND_SDC  = 2'd3;

  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;

  state_t     r_state;
  logic       r_armed;
  logic       r_sck_prev;
  logic [2:0] r_cnt;
  logic [7:0] r_rx;
  logic [7:0] r_tx;
  logic [7:0] r_target;
  logic       r_load_p1;
  logic       r_load_p2;
  logic       r_load_zero_p1;
  logic       r_load_zero_p2;

  logic       w_ss;
  logic       w_sck;
  logic       w_din;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_byte_done;
  logic [7:0] w_rx_byte;
  logic [1:0] w_kind;
  logic [7:0] w_reply;
  logic [7:0] w_load_byte;

  // Synchronise the asynchronous MCU pins. Reset clears the ss chain so a frame already
  // in progress at reset looks "low" and is never mistaken for a fresh ss falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_sync  <= '0;
      r_sck_sync <= '0;
      r_din_sync <= '0;
    end else begin
      r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0],  spi_io_ss};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_io_clk};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], spi_io_din};
    end
  end

  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_din       = r_din_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_prev;
  assign w_sck_fall  = ~w_sck & r_sck_prev;
  assign w_rx_byte   = {r_rx[6:0], w_din};
  assign w_byte_done = (r_state != ST_IDLE) && w_sck_rise && (r_cnt == 3'd7);

  // Decode the latched frame target; parameters are checked in priority order.
  always_comb begin
    w_kind = KIND_NONE;
    if (r_target == TARGET_SYS) begin
      w_kind = KIND_SYS;
    end else if (r_target == TARGET_HID) begin
      w_kind = KIND_HID;
    end else if (r_target == TARGET_SDC) begin
      w_kind = KIND_SDC;
    end else begin
      w_kind = KIND_NONE;
    end
  end

  // Select the reply byte of the addressed target; unknown targets reply 0x00.
  always_comb begin
    w_reply = 8'h00;
    case (w_kind)
      KIND_SYS: w_reply = mcu_sys_din;
      KIND_HID: w_reply = mcu_hid_din;
      KIND_SDC: w_reply = mcu_sdc_din;
      default:  w_reply = 8'h00;
    endcase
  end

  // The byte following the target byte is always answered with 0x00.
  always_comb begin
    w_load_byte = 8'h00;
    if (r_load_zero_p2) begin
      w_load_byte = 8'h00;
    end else begin
      w_load_byte = w_reply;
    end
  end

  // Frame state machine, byte assembly, strobe generation and MISO shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_armed        <= 1'b0;
      r_sck_prev     <= 1'b0;
      r_cnt          <= 3'd0;
      r_rx           <= 8'h00;
      r_tx           <= 8'h00;
      r_target       <= 8'h00;
      r_load_p1      <= 1'b0;
      r_load_p2      <= 1'b0;
      r_load_zero_p1 <= 1'b0;
      r_load_zero_p2 <= 1'b0;
      spi_io_dout    <= 1'b0;
      mcu_start      <= 1'b0;
      mcu_dout       <= 8'h00;
      mcu_sys_strb   <= 1'b0;
      mcu_hid_strb   <= 1'b0;
      mcu_sdc_strb   <= 1'b0;
    end else begin
      r_sck_prev     <= w_sck;
      mcu_sys_strb   <= 1'b0;
      mcu_hid_strb   <= 1'b0;
      mcu_sdc_strb   <= 1'b0;
      r_load_p1      <= w_byte_done;
      r_load_p2      <= r_load_p1;
      r_load_zero_p1 <= (r_state == ST_TGT);
      r_load_zero_p2 <= r_load_zero_p1;
      if (w_ss) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= 3'd0;
          // A frame starts only once ss has been seen high since reset.
          if (!w_ss && r_armed) begin
            r_state <= ST_TGT;
          end
        end
        default: begin
          if (w_sck_rise) begin
            r_rx  <= w_rx_byte;
            r_cnt <= r_cnt + 3'd1;
          end

          if (w_byte_done) begin
            mcu_dout <= w_rx_byte;
            case (r_state)
              ST_TGT: begin
                r_target  <= w_rx_byte;
                mcu_start <= 1'b0;
                r_state   <= ST_CMD;
              end
              ST_CMD: begin
                mcu_sys_strb <= (w_kind == KIND_SYS);
                mcu_hid_strb <= (w_kind == KIND_HID);
                mcu_sdc_strb <= (w_kind == KIND_SDC);
                mcu_start    <= 1'b1;
                r_state      <= ST_DATA;
              end
              ST_DATA: begin
                mcu_sys_strb <= (w_kind == KIND_SYS);
                mcu_hid_strb <= (w_kind == KIND_HID);
                mcu_sdc_strb <= (w_kind == KIND_SDC);
                mcu_start    <= 1'b0;
                r_state      <= ST_DATA;
              end
              default: r_state <= ST_IDLE;
            endcase
          end

          // The trailing falling edge after bit 0 (counter already wrapped) must not
          // disturb the freshly loaded reply byte.
          if (w_sck_fall && (r_cnt != 3'd0)) begin
            r_tx        <= {r_tx[6:0], 1'b0};
            spi_io_dout <= r_tx[6];
          end

          if (r_load_p2) begin
            r_tx        <= w_load_byte;
            spi_io_dout <= w_load_byte[7];
          end

          // ss release wins over everything except a byte completing in the same clk.
          if (w_ss) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_tx        <= 8'h00;
            spi_io_dout <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
